core_command_framer: RTL
========================

Name: core_command_framer

Overview:
- Upstream stage for the core interface. Accepts a byte stream from the host link (UART/SPI byte layer) over a valid/ready handshake.
- Assembles each command frame into instruction/address/value words and issues it to the core interface for exactly one cycle.
- After a fixed latency, captures the core interface result and returns it to the host as 4 bytes on a valid/ready byte output.
- Sits between the link byte layer and the core interface; one frame is in flight at a time.

Parameters:
- RESULT_LATENCY, 2, cycles from the issue cycle to the cycle result_i is sampled (legal range 1..15).
- TIMEOUT_CYCLES, 1000, idle cycles after which a partial frame is discarded; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- rx_data_i  in  8  incoming byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  framer accepts a byte this cycle
- tx_data_o  out  8  reply byte
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  downstream accepts tx byte
- instruction_o  out  8  to core interface; 0x00 = NOP
- address_o  out  24  to core interface
- value_o  out  32  to core interface
- result_i  in  32  from core interface result_o
- busy_o  out  1  high when the FSM is not in RX with zero bytes collected
- frame_err_o  out  1  one-cycle pulse on timeout abort or checksum failure

Behaviour:
- Reset (async assert; deassert synchronous to clk_i):
  - all outputs 0, FSM in RX, byte count 0, partial frame discarded.
  - A reset mid-frame, mid-wait or mid-TX aborts with no issue and no reply.
- Frame format (base): 8 bytes, MSB first.
  - byte0 = instruction
  - bytes1-3 = address[23:0]
  - bytes4-7 = value[31:0]
- States:
  - RX: rx_ready_o=1. Each rx_valid_i&rx_ready_o handshake shifts the byte in and increments the count. On the final byte, go to ISSUE if instruction≠0x00; otherwise return to RX with count 0 (NOP frame: no issue, no reply).
  - ISSUE (1 cycle): rx_ready_o=0. instruction_o = frame instruction. address_o/value_o updated from the frame, registered, visible this cycle. Next state WAIT.
  - WAIT: instruction_o=0. Counter runs RESULT_LATENCY cycles after ISSUE. result_i is sampled into a 32-bit shift register in the last WAIT cycle, which is the cycle at issue+RESULT_LATENCY. Next state TX.
  - TX: tx_valid_o=1, tx_data_o = result[31:24] first. Byte advances only on tx_valid_o&tx_ready_i; tx_data_o is held stable while tx_ready_i=0. After the 4th handshake, go to RX with tx_valid_o=0 the next cycle.
- instruction_o is 0x00 in every cycle except ISSUE.
- address_o/value_o hold the last issued values until the next ISSUE.
- rx_ready_o=0 in ISSUE/WAIT/TX. Bytes offered then are not consumed (back-pressure, no loss).
- Timeout:
  - In RX with count>0, an idle counter increments each cycle without a handshake and clears on each handshake.
  - When it reaches TIMEOUT_CYCLES: count→0, frame_err_o pulses 1 cycle, no issue.
  - A handshake in the same cycle the limit is reached wins: the byte is accepted and the counter clears.
- Back-to-back: the first byte of the next frame can be accepted the cycle after the last TX handshake.
- Total command latency: last rx byte handshake → ISSUE next cycle → first tx_valid_o at ISSUE+RESULT_LATENCY+1.

Optional Feature:
- Macro FRAMER_CHECKSUM_EN.
- Defined:
  - Frame is 9 bytes; byte8 = XOR of bytes0-7.
  - On the final byte, if the XOR of all 9 bytes ≠0x00: discard the frame, pulse frame_err_o, no issue, no reply, return to RX.
  - A NOP frame with a bad checksum also pulses frame_err_o.
- Undefined: 8-byte frame, no checksum, frame_err_o driven only by the timeout.

Test Plan:
- Reset then frame 01 00 00 02 00 00 00 05, result_i=0x0000000A at issue+2 → one cycle of instruction_o=0x01, address_o=0x000002, value_o=0x00000005; tx bytes 00 00 00 0A.
- tx_ready_i low 5 cycles during reply to result 0xDEADBEEF → tx_data_o holds DE; bytes exit DE AD BE EF; rx_ready_o stays 0 until the final handshake.
- NOP frame 00 12 34 56 00 00 00 01 → instruction_o stays 0x00, address_o unchanged, no tx_valid_o, ready for a new frame next cycle.
- TIMEOUT_CYCLES=10, send 3 bytes then idle 10 cycles → frame_err_o pulses once. A following full valid frame issues correctly.
- Assert rst_i during WAIT → all outputs 0 immediately (async); no reply after release; next frame processed normally.
- FRAMER_CHECKSUM_EN: frame 01 00 00 02 00 00 00 05 06 issues; same frame with byte8=07 → frame_err_o pulse, no issue.

Source files
------------

// File: rtl/core_command_framer.sv
// ============================================================================
// Module      : core_command_framer
// Description : Byte-stream command framer between the host link byte layer
//               and the core interface; issues one command, returns a 4-byte
//               reply. Optional checksum byte enabled by FRAMER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_command_framer #(
    parameter int RESULT_LATENCY = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  instruction_o,
    output logic [23:0] address_o,
    output logic [31:0] value_o,
    input  logic [31:0] result_i,
    output logic        busy_o,
    output logic        frame_err_o
);

    localparam logic [1:0] S_RX    = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_TX    = 2'd3;

`ifdef FRAMER_CHECKSUM_EN
    localparam int FRAME_BYTES = 9;
`else
    localparam int FRAME_BYTES = 8;
`endif

    localparam int               SHIFT_W    = (FRAME_BYTES - 1) * 8;
    localparam int               IDLE_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0]       LAST_BYTE  = 4'(FRAME_BYTES - 1);
    localparam logic [3:0]       LAT        = 4'(RESULT_LATENCY);

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [SHIFT_W-1:0]  frame_q, frame_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [3:0]          wait_q, wait_d;
    logic [1:0]          txcnt_q, txcnt_d;
    logic [31:0]         result_q, result_d;
    logic [7:0]          instr_q, instr_d;
    logic [23:0]         addr_q, addr_d;
    logic [31:0]         value_q, value_d;
    logic                rx_ready_q, rx_ready_d;
    logic                err_q, err_d;

    logic                   w_rx_hs;
    logic                   w_tx_hs;
    logic [FRAME_BYTES*8-1:0] w_frame_full;
    logic [7:0]             w_instr;
    logic [23:0]            w_addr;
    logic [31:0]            w_value;
    logic                   w_cksum_bad;

    assign w_rx_hs      = rx_valid_i & rx_ready_q;
    assign w_tx_hs      = tx_valid_o & tx_ready_i;
    // Frame as it stands including the byte being accepted this cycle.
    assign w_frame_full = {frame_q, rx_data_i};
    assign w_instr      = w_frame_full[FRAME_BYTES*8-1  -: 8];
    assign w_addr       = w_frame_full[FRAME_BYTES*8-9  -: 24];
    assign w_value      = w_frame_full[FRAME_BYTES*8-33 -: 32];

`ifdef FRAMER_CHECKSUM_EN
    logic [7:0] w_xor;
    always_comb begin
        w_xor = 8'h00;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            w_xor = w_xor ^ w_frame_full[i*8 +: 8];
        end
    end
    assign w_cksum_bad = (w_xor != 8'h00);
`else
    assign w_cksum_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        idle_d   = idle_q;
        wait_d   = wait_q;
        txcnt_d  = txcnt_q;
        result_d = result_q;
        instr_d  = 8'h00;
        addr_d   = addr_q;
        value_d  = value_q;
        err_d    = 1'b0;

        case (state_q)
            S_RX: begin
                if (w_rx_hs) begin
                    idle_d  = '0;
                    frame_d = w_frame_full[SHIFT_W-1:0];
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d = 4'd0;
                        if (w_cksum_bad) begin
                            err_d = 1'b1;
                        end else if (w_instr != 8'h00) begin
                            state_d = S_ISSUE;
                            instr_d = w_instr;
                            addr_d  = w_addr;
                            value_d = w_value;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if ((cnt_q != 4'd0) && (TIMEOUT_CYCLES != 0)) begin
                    if (idle_q == IDLE_LIMIT) begin
                        cnt_d  = 4'd0;
                        idle_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                wait_d  = 4'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Last WAIT cycle lands exactly RESULT_LATENCY cycles after ISSUE.
                if (wait_q == LAT) begin
                    result_d = result_i;
                    txcnt_d  = 2'd0;
                    state_d  = S_TX;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_TX: begin
                if (w_tx_hs) begin
                    result_d = {result_q[23:0], 8'h00};
                    txcnt_d  = txcnt_q + 2'd1;
                    if (txcnt_q == 2'd3) begin
                        state_d = S_RX;
                    end
                end
            end
            default: state_d = S_RX;
        endcase

        rx_ready_d = (state_d == S_RX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_RX;
            cnt_q      <= 4'd0;
            frame_q    <= '0;
            idle_q     <= '0;
            wait_q     <= 4'd0;
            txcnt_q    <= 2'd0;
            result_q   <= 32'd0;
            instr_q    <= 8'h00;
            addr_q     <= 24'd0;
            value_q    <= 32'd0;
            rx_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            idle_q     <= idle_d;
            wait_q     <= wait_d;
            txcnt_q    <= txcnt_d;
            result_q   <= result_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            value_q    <= value_d;
            rx_ready_q <= rx_ready_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready_o    = rx_ready_q;
    assign tx_valid_o    = (state_q == S_TX);
    assign tx_data_o     = result_q[31:24];
    assign instruction_o = instr_q;
    assign address_o     = addr_q;
    assign value_o       = value_q;
    assign busy_o        = (state_q != S_RX) || (cnt_q != 4'd0);
    assign frame_err_o   = err_q;

endmodule

`default_nettype wire
